fifo_status: RTL and testbench

Parametrised synchronous FIFO with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a defined simultaneous read/write policy at both boundaries. It is the next-generation buffer for the sequential-circuits library and replaces the plain full/empty FIFO wherever producers or consumers need early back-pressure or error visibility. Read latency is selectable at compile time: registered or first-word-fall-through.

---
 rtl/fifo_status_if.sv | 28 ++
 rtl/fifo_status.sv | 103 ++++++++++
 tb/tb_fifo_status.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fifo_status_if.sv
// Handshake and status bundle for fifo_status: producer/consumer requests in, data and occupancy status out.
interface fifo_status_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 128
);
   logic                     write;
   logic                     read;
   logic [WIDTH-1:0]         data_in;
   logic                     clr_err;
   logic [WIDTH-1:0]         data_out;
   logic                     full;
   logic                     empty;
   logic                     almost_full;
   logic                     almost_empty;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;
   logic                     underflow;

   modport master (
      output write, read, data_in, clr_err,
      input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  write, read, data_in, clr_err,
      output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_status.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise data_out is registered.
module fifo_status #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 128,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   fifo_status_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             overflow_q;
   logic             underflow_q;
   logic             full_w;
   logic             empty_w;
   logic             wr_ok;
   logic             rd_ok;
   logic             ovf_set;
   logic             udf_set;

   assign full_w  = (count_q == FULL_C);
   assign empty_w = (count_q == '0);

   // A full FIFO still accepts a write when a read frees the head slot in the same cycle.
   assign wr_ok   = bus.write && (!full_w || bus.read);
   assign rd_ok   = bus.read && !empty_w;
   assign ovf_set = bus.write && full_w && !bus.read;
   assign udf_set = bus.read && empty_w;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         // A fresh error in the clearing cycle keeps the flag set.
         if (ovf_set) begin
            overflow_q <= 1'b1;
         end else if (bus.clr_err) begin
            overflow_q <= 1'b0;
         end
         if (udf_set) begin
            underflow_q <= 1'b1;
         end else if (bus.clr_err) begin
            underflow_q <= 1'b0;
         end
      end
   end

`ifdef FIFO_FWFT_EN
   assign bus.data_out = empty_w ? '0 : mem[rd_ptr];
`else
   logic [WIDTH-1:0] data_out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q <= '0;
      end else if (rd_ok) begin
         data_out_q <= mem[rd_ptr];
      end
   end

   assign bus.data_out = data_out_q;
`endif

   assign bus.full         = full_w;
   assign bus.empty        = empty_w;
   assign bus.almost_full  = (count_q >= AF_C);
   assign bus.almost_empty = (count_q <= AE_C);
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_status.sv
// Scoreboard bench for fifo_status (DEPTH=8, AF=6, AE=2); works in either read-latency build.
module tb_fifo_status;
   localparam int W = 8;
   localparam int D = 8;

   logic clk;
   logic rst_n;

   fifo_status_if #(.WIDTH(W), .DEPTH(D)) bus ();

   fifo_status #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int tests_run = 0;
   int fails     = 0;

   logic [W-1:0] mq[$];
   logic [W-1:0] sb_q[$];
   logic         m_ovf = 1'b0;
   logic         m_udf = 1'b0;
   logic         pending = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever a read is accepted by the DUT.
   always @(negedge clk) begin
      if (!rst_n) begin
         pending = 1'b0;
      end else begin
         if (pending) begin
            pending = 1'b0;
            if (sb_q.size() == 0) begin
               chk("sb_underrun", 32'd1, 32'd0);
            end else begin
               chk("rd_data", 32'(bus.data_out), 32'(sb_q.pop_front()));
            end
         end
         if (bus.read && !bus.empty) begin
`ifdef FIFO_FWFT_EN
            if (sb_q.size() == 0) begin
               chk("sb_underrun", 32'd1, 32'd0);
            end else begin
               chk("rd_data", 32'(bus.data_out), 32'(sb_q.pop_front()));
            end
`else
            pending = 1'b1;
`endif
         end
      end
   end

   task automatic chk_status(input string tag);
      int n;
      n = mq.size();
      chk({tag, ".count"}, 32'(bus.count), 32'(n));
      chk({tag, ".full"}, 32'(bus.full), 32'(n == D));
      chk({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
      chk({tag, ".afull"}, 32'(bus.almost_full), 32'(n >= 6));
      chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'(n <= 2));
      chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
      chk({tag, ".udf"}, 32'(bus.underflow), 32'(m_udf));
   endtask

   task automatic step(input string tag, input logic w, input logic r,
                       input logic [W-1:0] d, input logic clr);
      logic m_wr, m_rd, e_ovf, e_udf;
      m_rd  = r && (mq.size() != 0);
      m_wr  = w && ((mq.size() != D) || r);
      e_ovf = w && (mq.size() == D) && !r;
      e_udf = r && (mq.size() == 0);
      if (m_rd) sb_q.push_back(mq.pop_front());
      if (m_wr) mq.push_back(d);
      m_ovf = e_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_udf = e_udf ? 1'b1 : (clr ? 1'b0 : m_udf);
      bus.write   = w;
      bus.read    = r;
      bus.data_in = d;
      bus.clr_err = clr;
      @(posedge clk);
      #1;
      bus.write   = 1'b0;
      bus.read    = 1'b0;
      bus.data_in = '0;
      bus.clr_err = 1'b0;
      chk_status(tag);
   endtask

   task automatic chk_reset_values();
      chk("rst.count", 32'(bus.count), 32'd0);
      chk("rst.empty", 32'(bus.empty), 32'd1);
      chk("rst.full", 32'(bus.full), 32'd0);
      chk("rst.aempty", 32'(bus.almost_empty), 32'd1);
      chk("rst.afull", 32'(bus.almost_full), 32'd0);
      chk("rst.ovf", 32'(bus.overflow), 32'd0);
      chk("rst.udf", 32'(bus.underflow), 32'd0);
      chk("rst.data_out", 32'(bus.data_out), 32'd0);
   endtask

   initial begin
      logic [W-1:0] rnd;
      rst_n       = 1'b0;
      bus.write   = 1'b0;
      bus.read    = 1'b0;
      bus.data_in = '0;
      bus.clr_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_values();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill: thresholds cross at count 3 (almost_empty low) and 6 (almost_full high).
      for (int i = 0; i < D; i++) step("fill", 1'b1, 1'b0, W'(8'h11 + i), 1'b0);

      step("ovf_write", 1'b1, 1'b0, 8'h19, 1'b0);
      step("clr_ovf", 1'b0, 1'b0, 8'h00, 1'b1);

      // Simultaneous write/read when full: head 0x11 leaves, 0xAA joins the tail.
      step("full_wr_rd", 1'b1, 1'b1, 8'hAA, 1'b0);
      for (int i = 0; i < D; i++) step("drain", 1'b0, 1'b1, 8'h00, 1'b0);

      step("udf_read", 1'b0, 1'b1, 8'h00, 1'b0);
      step("udf_clr_collide", 1'b0, 1'b1, 8'h00, 1'b1);
      step("clr_udf", 1'b0, 1'b0, 8'h00, 1'b1);

      // Empty with write+read: write taken, read rejected.
      step("empty_wr_rd", 1'b1, 1'b1, 8'h55, 1'b0);
      step("read_55", 1'b0, 1'b1, 8'h00, 1'b0);
      step("clr_udf2", 1'b0, 1'b0, 8'h00, 1'b1);

      for (int i = 0; i < 3; i++) step("prefill", 1'b1, 1'b0, W'(8'h30 + i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         rnd = W'($urandom_range(0, 255));
         step("wrap", 1'b1, 1'b1, rnd, 1'b0);
      end
      for (int i = 0; i < 3; i++) step("wrap_drain", 1'b0, 1'b1, 8'h00, 1'b0);

      // Reset mid-burst at count 5 discards contents.
      for (int i = 0; i < 5; i++) step("preburst", 1'b1, 1'b0, W'(8'h60 + i), 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_values();
      mq.delete();
      sb_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_status("post_rst");
      step("post_rst_wr", 1'b1, 1'b0, 8'h77, 1'b0);
      step("post_rst_rd", 1'b0, 1'b1, 8'h00, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
